// File: rtl/vga_pkg.sv
// Timing constants for 1440x900@60 (88.75 MHz pixel clock) and the shared raster bus type.
package vga_pkg;

  localparam int unsigned VGA_CNT_W = 11;

  localparam int unsigned HCOUNT_MAX        = 1599;
  localparam int unsigned VCOUNT_MAX        = 925;
  localparam int unsigned HBLNK_START_FRONT = 1439;
  localparam int unsigned VBLNK_START_FRONT = 900;
  localparam int unsigned HSYNC_START       = 1487;
  localparam int unsigned HSYNC_STOP        = 1518;
  localparam int unsigned VSYNC_START       = 902;
  localparam int unsigned VSYNC_STOP        = 907;

  typedef struct packed {
    logic [VGA_CNT_W-1:0] hcount;
    logic [VGA_CNT_W-1:0] vcount;
    logic                 hsync;
    logic                 vsync;
    logic                 hblnk;
    logic                 vblnk;
  } vga_tim_t;

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; wrap flags the increment that rolls over to 0.
module vga_wrap_counter
  import vga_pkg::*;
#(
  parameter int unsigned WIDTH = VGA_CNT_W,
  parameter int unsigned MAX   = HCOUNT_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Asserted even alongside clr; callers gate it where clear must win.
  assign wrap = inc && (cnt_q == WIDTH'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing.sv
// Free-running VGA raster generator: registered position, sync, blanking, line/frame strobes and
// a frame counter, with clock-enable stall and synchronous resync to (0,0).
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned HCNT_MAX  = HCOUNT_MAX,
  parameter int unsigned VCNT_MAX  = VCOUNT_MAX,
  parameter logic        HSYNC_POL = 1'b1,
  parameter logic        VSYNC_POL = 1'b1,
  parameter int unsigned FCNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 resync,
  output logic [VGA_CNT_W-1:0] hcount,
  output logic [VGA_CNT_W-1:0] vcount,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 hblnk,
  output logic                 vblnk,
  output logic                 line_start,
  output logic                 frame_start,
  output logic [FCNT_W-1:0]    frame_cnt
);

  localparam logic [VGA_CNT_W-1:0] HblnkTh = VGA_CNT_W'(HBLNK_START_FRONT);
  localparam logic [VGA_CNT_W-1:0] VblnkTh = VGA_CNT_W'(VBLNK_START_FRONT);
  localparam logic [VGA_CNT_W-1:0] HsLo    = VGA_CNT_W'(HSYNC_START);
  localparam logic [VGA_CNT_W-1:0] HsHi    = VGA_CNT_W'(HSYNC_STOP + 1);
  localparam logic [VGA_CNT_W-1:0] VsLo    = VGA_CNT_W'(VSYNC_START);
  localparam logic [VGA_CNT_W-1:0] VsHi    = VGA_CNT_W'(VSYNC_STOP + 1);

  logic [VGA_CNT_W-1:0] h_cnt, v_cnt;
  logic                 h_wrap, v_wrap;
  logic [VGA_CNT_W-1:0] h_nxt, v_nxt;

  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              hblnk_q, hblnk_d;
  logic              vblnk_q, vblnk_d;
  logic              line_start_q, line_start_d;
  logic              frame_start_q, frame_start_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  vga_wrap_counter #(
    .WIDTH (VGA_CNT_W),
    .MAX   (HCNT_MAX)
  ) u_h_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (resync),
    .inc   (en),
    .cnt   (h_cnt),
    .wrap  (h_wrap)
  );

  vga_wrap_counter #(
    .WIDTH (VGA_CNT_W),
    .MAX   (VCNT_MAX)
  ) u_v_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (resync),
    .inc   (en & h_wrap),
    .cnt   (v_cnt),
    .wrap  (v_wrap)
  );

  // Mirror of the counters' next state so decode lands in the same cycle as the position.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (resync) begin
      h_nxt = '0;
      v_nxt = '0;
    end else begin
      if (h_wrap) begin
        h_nxt = '0;
      end else if (en) begin
        h_nxt = h_cnt + VGA_CNT_W'(1);
      end
      if (v_wrap) begin
        v_nxt = '0;
      end else if (h_wrap) begin
        v_nxt = v_cnt + VGA_CNT_W'(1);
      end
    end
  end

  always_comb begin
    hblnk_d       = (h_nxt > HblnkTh);
    vblnk_d       = (v_nxt >= VblnkTh);
    hsync_d       = ((h_nxt > HsLo) && (h_nxt <= HsHi)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = ((v_nxt > VsLo) && (v_nxt <= VsHi)) ? VSYNC_POL : ~VSYNC_POL;
    line_start_d  = resync | h_wrap;
    frame_start_d = resync | v_wrap;
    frame_cnt_d   = frame_cnt_q;
    if (!resync && v_wrap) begin
      frame_cnt_d = frame_cnt_q + FCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign hcount      = h_cnt;
  assign vcount      = v_cnt;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: full-size raster (a), short-line/full-height raster (b), tiny raster with 2-bit
// frame counter (c), all sharing one set of inputs.
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst_n, en, resync;

  logic [10:0] hcount_a, vcount_a, hcount_b, vcount_b, hcount_c, vcount_c;
  logic hsync_a, vsync_a, hblnk_a, vblnk_a, ls_a, fs_a;
  logic hsync_b, vsync_b, hblnk_b, vblnk_b, ls_b, fs_b;
  logic hsync_c, vsync_c, hblnk_c, vblnk_c, ls_c, fs_c;
  logic [7:0] fc_a, fc_b;
  logic [1:0] fc_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_timing dut (
    .clk(clk), .rst_n(rst_n), .en(en), .resync(resync),
    .hcount(hcount_a), .vcount(vcount_a), .hsync(hsync_a), .vsync(vsync_a),
    .hblnk(hblnk_a), .vblnk(vblnk_a), .line_start(ls_a), .frame_start(fs_a),
    .frame_cnt(fc_a)
  );

  vga_timing #(.HCNT_MAX(15), .VCNT_MAX(925), .FCNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .resync(resync),
    .hcount(hcount_b), .vcount(vcount_b), .hsync(hsync_b), .vsync(vsync_b),
    .hblnk(hblnk_b), .vblnk(vblnk_b), .line_start(ls_b), .frame_start(fs_b),
    .frame_cnt(fc_b)
  );

  vga_timing #(.HCNT_MAX(7), .VCNT_MAX(3), .FCNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .resync(resync),
    .hcount(hcount_c), .vcount(vcount_c), .hsync(hsync_c), .vsync(vsync_c),
    .hblnk(hblnk_c), .vblnk(vblnk_c), .line_start(ls_c), .frame_start(fs_c),
    .frame_cnt(fc_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; resync = 1'b1;
    repeat (5) tick();
    checks++;
    if ({hcount_a, vcount_a, hsync_a, vsync_a, hblnk_a, vblnk_a, ls_a, fs_a, fc_a} !==
        {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL reset_state: h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b fc=%0d, required all 0",
               hcount_a, vcount_a, hsync_a, vsync_a, hblnk_a, vblnk_a, ls_a, fs_a, fc_a);
    end
    resync = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({hcount_a, vcount_a, hsync_a, vsync_a, hblnk_a, vblnk_a, ls_a, fs_a, fc_a} !==
        {11'd1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL first_edge: h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b fc=%0d, required h=1 rest 0",
               hcount_a, vcount_a, hsync_a, vsync_a, hblnk_a, vblnk_a, ls_a, fs_a, fc_a);
    end
  endtask

  task automatic test_line();
    int exp_h = 1;
    int exp_v = 0;
    int bad = 0;
    int ls_cnt = 0;
    int first_hs = -1;
    int last_hs = -1;
    int first_hb = -1;
    logic e_hb, e_hs;
    for (int i = 0; i < 1600; i++) begin
      tick();
      if (exp_h == 1599) begin
        exp_h = 0;
        exp_v = exp_v + 1;
      end else begin
        exp_h = exp_h + 1;
      end
      e_hb = (exp_h >= 1440);
      e_hs = (exp_h >= 1488) && (exp_h <= 1519);
      if (ls_a) ls_cnt++;
      if (hsync_a && first_hs < 0) first_hs = int'(hcount_a);
      if (hsync_a) last_hs = int'(hcount_a);
      if (hblnk_a && first_hb < 0) first_hb = int'(hcount_a);
      if (hcount_a !== 11'(exp_h) || vcount_a !== 11'(exp_v) || hblnk_a !== e_hb ||
          hsync_a !== e_hs || vsync_a !== 1'b0 || vblnk_a !== 1'b0 ||
          ls_a !== (exp_h == 0) || fs_a !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL line_sweep: mismatching cycles=%0d, required 0", bad);
    end
    checks++;
    if (ls_cnt != 1) begin
      failures++;
      $display("FAIL line_start_count: got %0d, required 1", ls_cnt);
    end
    checks++;
    if (first_hb != 1440) begin
      failures++;
      $display("FAIL hblnk_rise: got %0d, required 1440", first_hb);
    end
    checks++;
    if (first_hs != 1488 || last_hs != 1519) begin
      failures++;
      $display("FAIL hsync_window: got %0d..%0d, required 1488..1519", first_hs, last_hs);
    end
    checks++;
    if (hcount_a !== 11'd1 || vcount_a !== 11'd1) begin
      failures++;
      $display("FAIL line_end_pos: got (%0d,%0d), required (1,1)", hcount_a, vcount_a);
    end
  endtask

  task automatic test_frames();
    int hb = 0;
    int vb = 0;
    int fr = 0;
    int bad = 0;
    int fs_cnt = 0;
    int first_vs = -1;
    int last_vs = -1;
    int first_vb = -1;
    rst_n = 1'b0; en = 1'b1; resync = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2 * 16 * 926; i++) begin
      tick();
      if (hb == 15) begin
        hb = 0;
        if (vb == 925) begin
          vb = 0;
          fr++;
        end else begin
          vb++;
        end
      end else begin
        hb++;
      end
      if (fs_b) fs_cnt++;
      if (vsync_b && first_vs < 0) first_vs = int'(vcount_b);
      if (vsync_b) last_vs = int'(vcount_b);
      if (vblnk_b && first_vb < 0) first_vb = int'(vcount_b);
      if (hcount_b !== 11'(hb) || vcount_b !== 11'(vb) ||
          vsync_b !== ((vb >= 903) && (vb <= 908)) || vblnk_b !== (vb >= 900) ||
          ls_b !== (hb == 0) || fs_b !== (hb == 0 && vb == 0) || fc_b !== 8'(fr)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL frame_sweep: mismatching cycles=%0d, required 0", bad);
    end
    checks++;
    if (fs_cnt != 2) begin
      failures++;
      $display("FAIL frame_start_count: got %0d, required 2", fs_cnt);
    end
    checks++;
    if (fc_b !== 8'd2) begin
      failures++;
      $display("FAIL frame_cnt_two: got %0d, required 2", fc_b);
    end
    checks++;
    if (first_vs != 903 || last_vs != 908) begin
      failures++;
      $display("FAIL vsync_window: got %0d..%0d, required 903..908", first_vs, last_vs);
    end
    checks++;
    if (first_vb != 900) begin
      failures++;
      $display("FAIL vblnk_rise: got %0d, required 900", first_vb);
    end
  endtask

  task automatic test_hold();
    int bad = 0;
    rst_n = 1'b0; en = 1'b1; resync = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2300) tick();
    checks++;
    if (hcount_a !== 11'd700 || vcount_a !== 11'd1) begin
      failures++;
      $display("FAIL hold_entry: got (%0d,%0d), required (700,1)", hcount_a, vcount_a);
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (hcount_a !== 11'd700 || vcount_a !== 11'd1 || ls_a !== 1'b0 || fs_a !== 1'b0 ||
          hsync_a !== 1'b0 || hblnk_a !== 1'b0 || fc_a !== 8'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_frozen: mismatching cycles=%0d, required 0", bad);
    end
    en = 1'b1;
    tick();
    checks++;
    if (hcount_a !== 11'd701 || vcount_a !== 11'd1) begin
      failures++;
      $display("FAIL hold_resume: got (%0d,%0d), required (701,1)", hcount_a, vcount_a);
    end
  endtask

  task automatic test_resync();
    repeat (499) tick();
    // dut_c has seen 2800 enabled edges: 87 frames (mod 4 = 3) plus 16 pixels -> (0,2)
    checks++;
    if (hcount_a !== 11'd1200 || vcount_a !== 11'd1 || hcount_c !== 11'd0 ||
        vcount_c !== 11'd2 || fc_c !== 2'd3) begin
      failures++;
      $display("FAIL resync_entry: a=(%0d,%0d) c=(%0d,%0d) fc_c=%0d, required a=(1200,1) c=(0,2) fc_c=3",
               hcount_a, vcount_a, hcount_c, vcount_c, fc_c);
    end
    en = 1'b0;
    resync = 1'b1;
    tick();
    resync = 1'b0;
    checks++;
    if ({hcount_a, vcount_a, ls_a, fs_a, fc_a} !== {11'd0, 11'd0, 1'b1, 1'b1, 8'd0}) begin
      failures++;
      $display("FAIL resync_a: got (%0d,%0d) ls=%b fs=%b fc=%0d, required (0,0) ls=1 fs=1 fc=0",
               hcount_a, vcount_a, ls_a, fs_a, fc_a);
    end
    checks++;
    if ({hcount_c, vcount_c, ls_c, fs_c, fc_c} !== {11'd0, 11'd0, 1'b1, 1'b1, 2'd3}) begin
      failures++;
      $display("FAIL resync_fcnt_kept: got (%0d,%0d) ls=%b fs=%b fc=%0d, required (0,0) ls=1 fs=1 fc=3",
               hcount_c, vcount_c, ls_c, fs_c, fc_c);
    end
    tick();
    checks++;
    if ({hcount_a, vcount_a, ls_a, fs_a} !== {11'd0, 11'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL no_dup_strobe: got (%0d,%0d) ls=%b fs=%b, required (0,0) ls=0 fs=0",
               hcount_a, vcount_a, ls_a, fs_a);
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1;
    repeat (1500) tick();
    checks++;
    if ({hcount_a, vcount_a, hsync_a, hblnk_a} !== {11'd1500, 11'd0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL pre_reset: got (%0d,%0d) hs=%b hb=%b, required (1500,0) hs=1 hb=1",
               hcount_a, vcount_a, hsync_a, hblnk_a);
    end
    rst_n = 1'b0;
    resync = 1'b1;
    tick();
    checks++;
    if ({hcount_a, vcount_a, hsync_a, vsync_a, hblnk_a, vblnk_a, ls_a, fs_a, fc_a} !==
        {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL mid_reset: h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b fc=%0d, required all 0",
               hcount_a, vcount_a, hsync_a, vsync_a, hblnk_a, vblnk_a, ls_a, fs_a, fc_a);
    end
    resync = 1'b0;
  endtask

  task automatic test_fcnt_wrap();
    rst_n = 1'b0; en = 1'b1; resync = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      repeat (32) tick();
      checks++;
      if ({hcount_c, vcount_c, fs_c, fc_c} !== {11'd0, 11'd0, 1'b1, 2'(k % 4)}) begin
        failures++;
        $display("FAIL fcnt_wrap_%0d: got (%0d,%0d) fs=%b fc=%0d, required (0,0) fs=1 fc=%0d",
                 k, hcount_c, vcount_c, fs_c, fc_c, k % 4);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    resync = 1'b0;
    test_reset();
    test_line();
    test_frames();
    test_hold();
    test_resync();
    test_reset_mid();
    test_fcnt_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
